dpll_control_par: RTL and testbench
===================================

DPLL_CONTROL_PAR -- requirements
Module: dpll_control_par

Interface
REQ-001 Parameters (name, default, meaning): VAR_W, 8, variable index width; CLAUSE_W, 10, clause-table index width; LANES, 2, clause indices issued per cycle (1..8); CNT_W, 16, statistics and limit counter width.
REQ-002 Ports (name direction width meaning): clock in 1 system clock; reset in 1 asynchronous active-low reset; start in 1 begin-solve pulse; num_vars in VAR_W variable count; conflict_limit in CNT_W conflict abort threshold, where 0 means unlimited.
REQ-003 Imply queue ports: imp_empty in 1; imp_var in VAR_W head variable; imp_val in 1 head value; imp_pop out 1; imp_flush out 1, which discards the whole queue.
REQ-004 Trace stack ports: tr_empty in 1; tr_var in VAR_W; tr_val in 1; tr_type in 1 (0=decision, 1=implied/flipped) top entry; tr_push out 1; tr_pop out 1 (push+pop in one cycle = replace top); tr_var_in out VAR_W; tr_val_in out 1; tr_type_in out 1.
REQ-005 Var-state ports: vs_var out VAR_W address; vs_unassigned in 1 combinational read of vs_var; vs_write out 1; vs_val out 1; vs_unassign out 1.
REQ-006 Other table ports: vse_var out VAR_W; vse_start in CLAUSE_W; vse_end in CLAUSE_W, exclusive end, combinational; dec_idx out VAR_W; dec_var in VAR_W; dec_val in 1, combinational decider memory.
REQ-007 Decider stack ports: ds_push out 1; ds_pop out 1; ds_din out VAR_W; ds_dout in VAR_W top; ds_empty in 1.
REQ-008 BCP ports: bcp_valid out LANES per-lane strobe; bcp_idx out LANES*CLAUSE_W, lane k at bits [k*CLAUSE_W +: CLAUSE_W]; bcp_busy in 1; conflict in 1; bcp_clr out 1, which clears the BCP conflict flag.
REQ-009 Status ports: sat out 1; unsat out 1; aborted out 1; done out 1; state_out out 4; n_decisions out CNT_W; n_conflicts out CNT_W.

Function
REQ-010 States: IDLE, IMPLY, DECIDE, RANGE, ISSUE, WAIT, BT, SAT, UNSAT, ABORT; state and all counters are registered.
REQ-011 Strobes (imp_*, tr_*, vs_*, ds_*, bcp_valid, bcp_clr) are combinational decodes of the current state and inputs; each is high only in the cycle its action occurs.
REQ-012 IDLE or terminal state + start: clear sat/unsat/aborted, counters and dec_idx; go to IMPLY. start is ignored in all other states.
REQ-013 IMPLY, !imp_empty: imp_pop; vs_write with (imp_var, imp_val, unassign 0); tr_push with (imp_var, imp_val, type 1); cur_var<=imp_var; go to RANGE.
REQ-014 IMPLY, imp_empty: go to DECIDE.
REQ-015 DECIDE: vs_var=dec_var; the state tests one decider index per cycle.
REQ-016 DECIDE, dec_idx==num_vars: go to SAT.
REQ-017 DECIDE, vs_unassigned=1: vs_write (dec_var, dec_val, 0); tr_push (dec_var, dec_val, type 0); ds_push with ds_din=dec_idx; n_decisions++; dec_idx++; cur_var<=dec_var; go to RANGE.
REQ-018 DECIDE, otherwise: dec_idx++ and remain in DECIDE.
REQ-019 RANGE: vse_var=cur_var; ptr<=vse_start; lim<=vse_end. If vse_start>=vse_end, go to WAIT; else go to ISSUE.
REQ-020 ISSUE: lane k has bcp_valid[k]=(ptr+k<lim) and bcp_idx[k]=ptr+k; ptr+=LANES; when ptr+LANES>=lim, go to WAIT. All compare/add uses CLAUSE_W+1 bits, with no wrap-around.
REQ-021 WAIT: conflict has priority over completion.
REQ-022 WAIT, conflict: imp_flush; n_conflicts++. If conflict_limit!=0 and the incremented count equals conflict_limit, go to ABORT; else bcp_clr and go to BT.
REQ-023 WAIT, !conflict && !bcp_busy: go to IMPLY. Otherwise remain in WAIT.
REQ-024 BT, tr_empty: go to UNSAT.
REQ-025 BT, tr_type=1: tr_pop; vs_write with (tr_var, unassign 1); remain in BT, one entry per cycle.
REQ-026 BT, tr_type=0: tr_pop+tr_push as a replace with (tr_var, ~tr_val, type 1); vs_write (tr_var, ~tr_val, 0); ds_pop; dec_idx<=ds_dout+1; cur_var<=tr_var; go to RANGE.
REQ-027 BT with tr_type=0 and ds_empty is a protocol error: treat dec_idx as 0 and assert no ds_pop.
REQ-028 SAT/UNSAT/ABORT: the matching flag is 1 and done=1; all strobes are 0; hold until start.
REQ-029 Counters saturate at all-ones; state_out carries the state encoding in REQ-010 order, IDLE=0.

Reset
REQ-030 reset=0 asynchronously forces IDLE, with all registers, flags, counters, dec_idx, ptr, lim and cur_var at 0; all strobes are then 0 in the same cycle.
REQ-031 Reset in any state, including mid-ISSUE or mid-BT, abandons the operation; no further strobe occurs until start after reset is released.

Verification
REQ-032 num_vars=0, imply queue empty, start: IMPLY, then DECIDE, then SAT; sat=1, done=1, n_decisions=0.
REQ-033 LANES=2, implied var with vse_start=4, vse_end=9: ISSUE gives bcp_valid 11/11/01 with bcp_idx {4,5},{6,7},{8,x}, then WAIT.
REQ-034 One free var, decision val 1 conflicts, flipped val 0 conflicts: first BT is a replace (type 1, val 0) with ds_pop; second BT pops and unassigns, then tr_empty gives UNSAT; n_conflicts=2.
REQ-035 conflict_limit=1, first conflict: ABORT with aborted=1, done=1, imp_flush=1 and bcp_clr=0 in that cycle.
REQ-036 WAIT with conflict=1 and bcp_busy=0 in the same cycle: go to BT, not IMPLY.
REQ-037 reset=0 during ISSUE: bcp_valid=0 immediately and state_out=0; after release, the block stays idle until start.

Source files
------------

// File: rtl/dpll_control_par.sv
// DPLL search controller: imply/decide/backtrack sequencing with a multi-lane
// clause-index issuer feeding the BCP engine.
module dpll_control_par #(
    parameter int VAR_W    = 8,
    parameter int CLAUSE_W = 10,
    parameter int LANES    = 2,
    parameter int CNT_W    = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [VAR_W-1:0]          num_vars,
    input  logic [CNT_W-1:0]          conflict_limit,
    input  logic                      imp_empty,
    input  logic [VAR_W-1:0]          imp_var,
    input  logic                      imp_val,
    output logic                      imp_pop,
    output logic                      imp_flush,
    input  logic                      tr_empty,
    input  logic [VAR_W-1:0]          tr_var,
    input  logic                      tr_val,
    input  logic                      tr_type,
    output logic                      tr_push,
    output logic                      tr_pop,
    output logic [VAR_W-1:0]          tr_var_in,
    output logic                      tr_val_in,
    output logic                      tr_type_in,
    output logic [VAR_W-1:0]          vs_var,
    input  logic                      vs_unassigned,
    output logic                      vs_write,
    output logic                      vs_val,
    output logic                      vs_unassign,
    output logic [VAR_W-1:0]          vse_var,
    input  logic [CLAUSE_W-1:0]       vse_start,
    input  logic [CLAUSE_W-1:0]       vse_end,
    output logic [VAR_W-1:0]          dec_idx,
    input  logic [VAR_W-1:0]          dec_var,
    input  logic                      dec_val,
    output logic                      ds_push,
    output logic                      ds_pop,
    output logic [VAR_W-1:0]          ds_din,
    input  logic [VAR_W-1:0]          ds_dout,
    input  logic                      ds_empty,
    output logic [LANES-1:0]          bcp_valid,
    output logic [LANES*CLAUSE_W-1:0] bcp_idx,
    input  logic                      bcp_busy,
    input  logic                      conflict,
    output logic                      bcp_clr,
    output logic                      sat,
    output logic                      unsat,
    output logic                      aborted,
    output logic                      done,
    output logic [3:0]                state_out,
    output logic [CNT_W-1:0]          n_decisions,
    output logic [CNT_W-1:0]          n_conflicts
);

    localparam int PW = CLAUSE_W + 1;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        IMPLY  = 4'd1,
        DECIDE = 4'd2,
        RANGE  = 4'd3,
        ISSUE  = 4'd4,
        WAIT   = 4'd5,
        BT     = 4'd6,
        SAT    = 4'd7,
        UNSAT  = 4'd8,
        ABORT  = 4'd9
    } state_t;

    state_t            state_q, state_d;
    logic [VAR_W-1:0]  dec_idx_q, dec_idx_d;
    logic [VAR_W-1:0]  cur_var_q, cur_var_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     lim_q, lim_d;
    logic [CNT_W-1:0]  n_dec_q, n_dec_d;
    logic [CNT_W-1:0]  n_conf_q, n_conf_d;

    logic [PW-1:0]     ptr_next;
    logic [CNT_W-1:0]  conf_inc;
    logic              abort_hit;
    logic              dec_take;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign ptr_next  = ptr_q + PW'(LANES);
    assign conf_inc  = sat_inc(n_conf_q);
    assign abort_hit = (conflict_limit != '0) && (conf_inc == conflict_limit);
    assign dec_take  = (dec_idx_q != num_vars) && vs_unassigned;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            dec_idx_q <= '0;
            cur_var_q <= '0;
            ptr_q     <= '0;
            lim_q     <= '0;
            n_dec_q   <= '0;
            n_conf_q  <= '0;
        end else begin
            state_q   <= state_d;
            dec_idx_q <= dec_idx_d;
            cur_var_q <= cur_var_d;
            ptr_q     <= ptr_d;
            lim_q     <= lim_d;
            n_dec_q   <= n_dec_d;
            n_conf_q  <= n_conf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dec_idx_d = dec_idx_q;
        cur_var_d = cur_var_q;
        ptr_d     = ptr_q;
        lim_d     = lim_q;
        n_dec_d   = n_dec_q;
        n_conf_d  = n_conf_q;
        case (state_q)
            IDLE, SAT, UNSAT, ABORT: begin
                if (start) begin
                    state_d   = IMPLY;
                    dec_idx_d = '0;
                    n_dec_d   = '0;
                    n_conf_d  = '0;
                end
            end
            IMPLY: begin
                if (!imp_empty) begin
                    cur_var_d = imp_var;
                    state_d   = RANGE;
                end else begin
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                if (dec_idx_q == num_vars) begin
                    state_d = SAT;
                end else begin
                    dec_idx_d = dec_idx_q + 1'b1;
                    if (vs_unassigned) begin
                        n_dec_d   = sat_inc(n_dec_q);
                        cur_var_d = dec_var;
                        state_d   = RANGE;
                    end
                end
            end
            RANGE: begin
                ptr_d   = {1'b0, vse_start};
                lim_d   = {1'b0, vse_end};
                state_d = (vse_start >= vse_end) ? WAIT : ISSUE;
            end
            ISSUE: begin
                ptr_d = ptr_next;
                if (ptr_next >= lim_q) state_d = WAIT;
            end
            WAIT: begin
                if (conflict) begin
                    n_conf_d = conf_inc;
                    state_d  = abort_hit ? ABORT : BT;
                end else if (!bcp_busy) begin
                    state_d = IMPLY;
                end
            end
            BT: begin
                if (tr_empty) begin
                    state_d = UNSAT;
                end else if (!tr_type) begin
                    // An empty decider stack here is a protocol error; restart the scan from 0.
                    dec_idx_d = ds_empty ? '0 : ds_dout + 1'b1;
                    cur_var_d = tr_var;
                    state_d   = RANGE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imp_pop     = 1'b0;
        imp_flush   = 1'b0;
        tr_push     = 1'b0;
        tr_pop      = 1'b0;
        tr_var_in   = '0;
        tr_val_in   = 1'b0;
        tr_type_in  = 1'b0;
        vs_var      = '0;
        vs_write    = 1'b0;
        vs_val      = 1'b0;
        vs_unassign = 1'b0;
        ds_push     = 1'b0;
        ds_pop      = 1'b0;
        ds_din      = '0;
        bcp_valid   = '0;
        bcp_idx     = '0;
        bcp_clr     = 1'b0;
        case (state_q)
            IMPLY: begin
                if (!imp_empty) begin
                    imp_pop    = 1'b1;
                    vs_var     = imp_var;
                    vs_write   = 1'b1;
                    vs_val     = imp_val;
                    tr_push    = 1'b1;
                    tr_var_in  = imp_var;
                    tr_val_in  = imp_val;
                    tr_type_in = 1'b1;
                end
            end
            DECIDE: begin
                vs_var = dec_var;
                if (dec_take) begin
                    vs_write  = 1'b1;
                    vs_val    = dec_val;
                    tr_push   = 1'b1;
                    tr_var_in = dec_var;
                    tr_val_in = dec_val;
                    ds_push   = 1'b1;
                    ds_din    = dec_idx_q;
                end
            end
            ISSUE: begin
                for (int k = 0; k < LANES; k++) begin
                    bcp_valid[k] = (ptr_q + PW'(k)) < lim_q;
                    bcp_idx[k*CLAUSE_W +: CLAUSE_W] = ptr_q[CLAUSE_W-1:0] + CLAUSE_W'(k);
                end
            end
            WAIT: begin
                if (conflict) begin
                    imp_flush = 1'b1;
                    bcp_clr   = !abort_hit;
                end
            end
            BT: begin
                if (!tr_empty) begin
                    tr_pop   = 1'b1;
                    vs_var   = tr_var;
                    vs_write = 1'b1;
                    if (tr_type) begin
                        vs_unassign = 1'b1;
                    end else begin
                        tr_push    = 1'b1;
                        tr_var_in  = tr_var;
                        tr_val_in  = ~tr_val;
                        tr_type_in = 1'b1;
                        vs_val     = ~tr_val;
                        ds_pop     = !ds_empty;
                    end
                end
            end
            default: ;
        endcase
    end

    assign vse_var     = cur_var_q;
    assign dec_idx     = dec_idx_q;
    assign state_out   = state_q;
    assign n_decisions = n_dec_q;
    assign n_conflicts = n_conf_q;
    assign sat         = (state_q == SAT);
    assign unsat       = (state_q == UNSAT);
    assign aborted     = (state_q == ABORT);
    assign done        = sat | unsat | aborted;

endmodule

// File: tb/tb_dpll_control_par.sv
// Directed bench for dpll_control_par: environment inputs are driven by hand and
// expected outputs flow through a scoreboard queue.
module tb_dpll_control_par;

    localparam int VAR_W    = 8;
    localparam int CLAUSE_W = 10;
    localparam int LANES    = 2;
    localparam int CNT_W    = 16;

    logic                      clock = 1'b0;
    logic                      reset;
    logic                      start;
    logic [VAR_W-1:0]          num_vars;
    logic [CNT_W-1:0]          conflict_limit;
    logic                      imp_empty;
    logic [VAR_W-1:0]          imp_var;
    logic                      imp_val;
    logic                      imp_pop;
    logic                      imp_flush;
    logic                      tr_empty;
    logic [VAR_W-1:0]          tr_var;
    logic                      tr_val;
    logic                      tr_type;
    logic                      tr_push;
    logic                      tr_pop;
    logic [VAR_W-1:0]          tr_var_in;
    logic                      tr_val_in;
    logic                      tr_type_in;
    logic [VAR_W-1:0]          vs_var;
    logic                      vs_unassigned;
    logic                      vs_write;
    logic                      vs_val;
    logic                      vs_unassign;
    logic [VAR_W-1:0]          vse_var;
    logic [CLAUSE_W-1:0]       vse_start;
    logic [CLAUSE_W-1:0]       vse_end;
    logic [VAR_W-1:0]          dec_idx;
    logic [VAR_W-1:0]          dec_var;
    logic                      dec_val;
    logic                      ds_push;
    logic                      ds_pop;
    logic [VAR_W-1:0]          ds_din;
    logic [VAR_W-1:0]          ds_dout;
    logic                      ds_empty;
    logic [LANES-1:0]          bcp_valid;
    logic [LANES*CLAUSE_W-1:0] bcp_idx;
    logic                      bcp_busy;
    logic                      conflict;
    logic                      bcp_clr;
    logic                      sat;
    logic                      unsat;
    logic                      aborted;
    logic                      done;
    logic [3:0]                state_out;
    logic [CNT_W-1:0]          n_decisions;
    logic [CNT_W-1:0]          n_conflicts;

    logic [CLAUSE_W-1:0] lane0, lane1;
    assign lane0 = bcp_idx[CLAUSE_W-1:0];
    assign lane1 = bcp_idx[2*CLAUSE_W-1:CLAUSE_W];

    always #5 clock = ~clock;

    dpll_control_par #(
        .VAR_W(VAR_W), .CLAUSE_W(CLAUSE_W), .LANES(LANES), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .num_vars(num_vars),
        .conflict_limit(conflict_limit),
        .imp_empty(imp_empty), .imp_var(imp_var), .imp_val(imp_val),
        .imp_pop(imp_pop), .imp_flush(imp_flush),
        .tr_empty(tr_empty), .tr_var(tr_var), .tr_val(tr_val), .tr_type(tr_type),
        .tr_push(tr_push), .tr_pop(tr_pop), .tr_var_in(tr_var_in),
        .tr_val_in(tr_val_in), .tr_type_in(tr_type_in),
        .vs_var(vs_var), .vs_unassigned(vs_unassigned), .vs_write(vs_write),
        .vs_val(vs_val), .vs_unassign(vs_unassign),
        .vse_var(vse_var), .vse_start(vse_start), .vse_end(vse_end),
        .dec_idx(dec_idx), .dec_var(dec_var), .dec_val(dec_val),
        .ds_push(ds_push), .ds_pop(ds_pop), .ds_din(ds_din), .ds_dout(ds_dout),
        .ds_empty(ds_empty),
        .bcp_valid(bcp_valid), .bcp_idx(bcp_idx), .bcp_busy(bcp_busy),
        .conflict(conflict), .bcp_clr(bcp_clr),
        .sat(sat), .unsat(unsat), .aborted(aborted), .done(done),
        .state_out(state_out), .n_decisions(n_decisions), .n_conflicts(n_conflicts)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_item_t;

    sb_item_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic sb_push(input string tag, input logic [31:0] val);
        sb_item_t it;
        it.tag = tag;
        it.val = val;
        sb.push_back(it);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        sb_item_t it;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_underflow observed=%0h expected=none", obs);
        end else begin
            it = sb.pop_front();
            assert (obs === it.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", it.tag, obs, it.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; num_vars = '0; conflict_limit = '0;
        imp_empty = 1'b1; imp_var = '0; imp_val = 1'b0;
        tr_empty = 1'b1; tr_var = '0; tr_val = 1'b0; tr_type = 1'b0;
        vs_unassigned = 1'b0; vse_start = '0; vse_end = '0;
        dec_var = '0; dec_val = 1'b0; ds_dout = '0; ds_empty = 1'b1;
        bcp_busy = 1'b0; conflict = 1'b0;

        // Reset state
        sb_push("rst_state", 0); sb_push("rst_done", 0); sb_push("rst_ndec", 0);
        sb_push("rst_nconf", 0); sb_push("rst_valid", 0); sb_push("rst_decidx", 0);
        #3;
        sb_check(32'(state_out)); sb_check(32'(done)); sb_check(32'(n_decisions));
        sb_check(32'(n_conflicts)); sb_check(32'(bcp_valid)); sb_check(32'(dec_idx));
        tick();
        reset = 1'b1;

        // Trivial SAT: no variables, empty imply queue
        start = 1'b1; num_vars = 8'd0;
        tick();
        start = 1'b0;
        sb_push("a_imply", 1); sb_check(32'(state_out));
        tick();
        sb_push("a_decide", 2); sb_check(32'(state_out));
        tick();
        sb_push("a_sat_state", 7); sb_push("a_sat", 1); sb_push("a_done", 1); sb_push("a_ndec", 0);
        sb_check(32'(state_out)); sb_check(32'(sat)); sb_check(32'(done)); sb_check(32'(n_decisions));

        // Implied var, clause range [4,9) over two lanes
        start = 1'b1; num_vars = 8'd1;
        tick();
        start = 1'b0; imp_empty = 1'b0; imp_var = 8'd5; imp_val = 1'b1;
        sb_push("b_imp_pop", 1); sb_push("b_vs_write", 1); sb_push("b_vs_var", 5);
        sb_push("b_vs_val", 1); sb_push("b_tr_push", 1); sb_push("b_tr_type", 1); sb_push("b_tr_var", 5);
        #1;
        sb_check(32'(imp_pop)); sb_check(32'(vs_write)); sb_check(32'(vs_var));
        sb_check(32'(vs_val)); sb_check(32'(tr_push)); sb_check(32'(tr_type_in)); sb_check(32'(tr_var_in));
        tick();
        imp_empty = 1'b1; vse_start = 10'd4; vse_end = 10'd9;
        sb_push("b_range", 3); sb_push("b_vse_var", 5);
        #1;
        sb_check(32'(state_out)); sb_check(32'(vse_var));
        tick();
        sb_push("b_v0", 3); sb_push("b_i00", 4); sb_push("b_i01", 5);
        sb_check(32'(bcp_valid)); sb_check(32'(lane0)); sb_check(32'(lane1));
        tick();
        sb_push("b_v1", 3); sb_push("b_i10", 6); sb_push("b_i11", 7);
        sb_check(32'(bcp_valid)); sb_check(32'(lane0)); sb_check(32'(lane1));
        tick();
        sb_push("b_v2", 1); sb_push("b_i20", 8); sb_push("b_issue_state", 4);
        sb_check(32'(bcp_valid)); sb_check(32'(lane0)); sb_check(32'(state_out));
        tick();
        bcp_busy = 1'b1;
        sb_push("b_wait", 5); sb_push("b_wait_valid", 0);
        sb_check(32'(state_out)); sb_check(32'(bcp_valid));
        tick();
        sb_push("b_wait_busy", 5); sb_check(32'(state_out));
        bcp_busy = 1'b0;
        tick();
        sb_push("b_back_imply", 1); sb_check(32'(state_out));
        tick();
        vs_unassigned = 1'b0;
        sb_push("b_decide", 2); sb_push("b_no_dspush", 0);
        #1;
        sb_check(32'(state_out)); sb_check(32'(ds_push));
        tick();
        sb_push("b_skip_idx", 1); sb_push("b_skip_state", 2);
        sb_check(32'(dec_idx)); sb_check(32'(state_out));
        tick();
        sb_push("b_sat", 1); sb_push("b_ndec", 0);
        sb_check(32'(sat)); sb_check(32'(n_decisions));

        // One free var: decision and its flip both conflict
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        dec_var = 8'd3; dec_val = 1'b1; vs_unassigned = 1'b1;
        sb_push("c_vs_var", 3); sb_push("c_vs_write", 1); sb_push("c_vs_val", 1);
        sb_push("c_tr_push", 1); sb_push("c_tr_type", 0); sb_push("c_ds_push", 1); sb_push("c_ds_din", 0);
        #1;
        sb_check(32'(vs_var)); sb_check(32'(vs_write)); sb_check(32'(vs_val));
        sb_check(32'(tr_push)); sb_check(32'(tr_type_in)); sb_check(32'(ds_push)); sb_check(32'(ds_din));
        tick();
        vs_unassigned = 1'b0; vse_start = 10'd2; vse_end = 10'd2;
        sb_push("c_range", 3); sb_push("c_ndec", 1);
        sb_check(32'(state_out)); sb_check(32'(n_decisions));
        tick();
        conflict = 1'b1; bcp_busy = 1'b0;
        sb_push("c_wait", 5); sb_push("c_flush", 1); sb_push("c_clr", 1);
        #1;
        sb_check(32'(state_out)); sb_check(32'(imp_flush)); sb_check(32'(bcp_clr));
        tick();
        conflict = 1'b0;
        tr_empty = 1'b0; tr_var = 8'd3; tr_val = 1'b1; tr_type = 1'b0; ds_empty = 1'b0; ds_dout = 8'd0;
        sb_push("c_bt", 6); sb_push("c_nconf1", 1);
        sb_push("c_tr_pop", 1); sb_push("c_tr_rpush", 1); sb_push("c_tr_val_in", 0);
        sb_push("c_tr_type_in", 1); sb_push("c_ds_pop", 1); sb_push("c_bt_vs_val", 0); sb_push("c_bt_unas", 0);
        #1;
        sb_check(32'(state_out)); sb_check(32'(n_conflicts));
        sb_check(32'(tr_pop)); sb_check(32'(tr_push)); sb_check(32'(tr_val_in));
        sb_check(32'(tr_type_in)); sb_check(32'(ds_pop)); sb_check(32'(vs_val)); sb_check(32'(vs_unassign));
        tick();
        tr_empty = 1'b1; ds_empty = 1'b1;
        sb_push("c_range2", 3); sb_push("c_decidx", 1);
        sb_check(32'(state_out)); sb_check(32'(dec_idx));
        tick();
        conflict = 1'b1;
        tick();
        conflict = 1'b0;
        tr_empty = 1'b0; tr_var = 8'd3; tr_val = 1'b0; tr_type = 1'b1;
        sb_push("c_bt2", 6); sb_push("c_nconf2", 2); sb_push("c_pop2", 1);
        sb_push("c_push2", 0); sb_push("c_unas2", 1); sb_push("c_dspop2", 0);
        #1;
        sb_check(32'(state_out)); sb_check(32'(n_conflicts)); sb_check(32'(tr_pop));
        sb_check(32'(tr_push)); sb_check(32'(vs_unassign)); sb_check(32'(ds_pop));
        tick();
        tr_empty = 1'b1;
        sb_push("c_bt_hold", 6); sb_check(32'(state_out));
        tick();
        tr_empty = 1'b0;
        sb_push("c_unsat_state", 8); sb_push("c_unsat", 1); sb_push("c_done", 1);
        sb_push("c_nconf", 2); sb_push("c_term_pop", 0);
        #1;
        sb_check(32'(state_out)); sb_check(32'(unsat)); sb_check(32'(done));
        sb_check(32'(n_conflicts)); sb_check(32'(tr_pop));
        tr_empty = 1'b1;

        // Conflict limit of 1 aborts on the first conflict
        conflict_limit = 16'd1; start = 1'b1;
        tick();
        start = 1'b0; imp_empty = 1'b0; imp_var = 8'd2;
        tick();
        imp_empty = 1'b1; vse_start = 10'd2; vse_end = 10'd2;
        tick();
        conflict = 1'b1;
        sb_push("d_flush", 1); sb_push("d_clr", 0);
        #1;
        sb_check(32'(imp_flush)); sb_check(32'(bcp_clr));
        tick();
        conflict = 1'b0;
        sb_push("d_state", 9); sb_push("d_aborted", 1); sb_push("d_done", 1);
        sb_push("d_nconf", 1); sb_push("d_sat", 0);
        sb_check(32'(state_out)); sb_check(32'(aborted)); sb_check(32'(done));
        sb_check(32'(n_conflicts)); sb_check(32'(sat));

        // Reset asserted mid-ISSUE
        conflict_limit = 16'd0; start = 1'b1;
        tick();
        start = 1'b0; imp_empty = 1'b0; imp_var = 8'd5;
        tick();
        imp_empty = 1'b1; vse_start = 10'd4; vse_end = 10'd9;
        tick();
        sb_push("e_issue_valid", 3); sb_check(32'(bcp_valid));
        reset = 1'b0;
        sb_push("e_rst_valid", 0); sb_push("e_rst_state", 0); sb_push("e_rst_nconf", 0);
        #1;
        sb_check(32'(bcp_valid)); sb_check(32'(state_out)); sb_check(32'(n_conflicts));
        #1;
        reset = 1'b1;
        imp_empty = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            sb_push("e_idle_state", 0); sb_push("e_idle_valid", 0); sb_push("e_idle_pop", 0);
            sb_check(32'(state_out)); sb_check(32'(bcp_valid)); sb_check(32'(imp_pop));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
